pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries a WIDTH-bit stage payload (control fields and data) between stages using valid/ready.
- Holds the payload on stall, with a one-entry skid buffer so that in_ready is registered.
- Supports flush (bubble insertion) and forces the masked control bits to zero on any bubble.
- Counts stall cycles for performance debug.

Parameters:
- WIDTH, 32, payload width in bits.
- CTRL_MASK, {WIDTH{1'b0}}, bits set to 1 are control bits (RegWrite, MemWrite, ...); they are forced to 0 whenever out_valid=0.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload; registered, no combinational path from out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload; CTRL_MASK bits are 0 when out_valid=0.
- flush  in  1  discard all held entries (branch/jump/exception kill).
- clr_stats  in  1  clear stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset=0 at posedge): state=EMPTY, main and skid data = 0, in_ready=1, out_valid=0, out_data=0, stall_cnt=0, occupancy=0. Reset overrides flush and clr_stats.
- States (package enum): EMPTY (occ 0), FULL (main only, occ 1), SKID (main+skid, occ 2).
- EMPTY: in_fire -> FULL, main<=in_data.
- FULL, in_fire & out_fire -> FULL, main<=in_data.
- FULL, in_fire & !out_fire -> SKID, skid<=in_data.
- FULL, !in_fire & out_fire -> EMPTY.
- FULL, neither -> hold.
- SKID: in_ready=0. out_fire -> FULL, main<=skid. Otherwise hold.
- Outputs derived from state: out_valid = (state!=EMPTY); in_ready = (state!=SKID), implemented as a flop updated with next-state.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Full throughput: 1 transfer per cycle when out_ready=1 continuously.
- Ordering: strictly FIFO; skid contents are never presented before main.
- Flush: next state EMPTY and in_ready=1 regardless of handshake. An in_fire in the flush cycle is discarded. out_data control bits read 0 from the next cycle. Non-control bits of main and skid keep their old values; they are don't-care but must not be X after reset.
- Bubble masking: out_data = main & ~CTRL_MASK when out_valid=0, otherwise main.
- stall_cnt: increments when out_valid & !out_ready and flush=0, saturating at 2^CNT_W-1. clr_stats has priority over increment, so clear plus stall in the same cycle gives 0.
- The same flops serve as a plain latch: with in_valid tied 1 and out_ready driven by ~stall, the block behaves as a stall-able IF/ID register.

Decomposition:
- Package pipe_pkg: state enum (EMPTY=2'd0, FULL=2'd1, SKID=2'd2), default WIDTH/CNT_W constants, and per-stage CTRL_MASK constants (IFID_CTRL_MASK, IDEX_CTRL_MASK, EXMEM_CTRL_MASK, MEMWB_CTRL_MASK).
- One sub-module, sat_counter (parameter CNT_W; inputs inc, clr; output count), used for stall_cnt.

Test Plan:
- Reset, then in_valid=1, in_data=32'h1234_5678, out_ready=1 -> out_valid=1 with out_data=32'h1234_5678 one cycle later; in_ready stays 1; occupancy=1.
- Stream 0x1,0x2,0x3, drop out_ready for 2 cycles after the first accept -> in_ready falls after the second entry is held (occupancy=2). On release, output sequence is exactly 0x1,0x2,0x3 with no loss or duplication; stall_cnt=2.
- CTRL_MASK=32'hF000_0000, FULL holding 32'hF0F0_0001, assert flush for 1 cycle with in_valid=1, in_data=32'hFFFF_FFFF -> out_valid=0 next cycle, out_data[31:28]=0, incoming word discarded, in_ready=1.
- State SKID, assert reset=0 for 1 cycle -> all outputs at reset values; the next in_fire of 0xAB appears as the first output.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Assert clr_stats while still stalled -> stall_cnt=0, then 1 on the following cycle.
- Randomised valid/ready with a scoreboard for 10k cycles -> output order matches input order, never more than 2 held entries, and in_ready is never a combinational function of out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the handshaked pipeline stage register:
//   - pipe_state_e   : occupancy state of a stage (EMPTY / FULL / SKID)
//   - PIPE_WIDTH     : default payload width
//   - PIPE_CNT_W     : default stall counter width
//   - *_CTRL_MASK    : per-stage control-bit masks for a 32-bit payload layout
//                      where control fields live in the upper bits
//   - state_occ()    : number of held entries for a given state
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing held
      FULL  = 2'd1,   // main entry held
      SKID  = 2'd2    // main and skid entries held
   } pipe_state_e;

   localparam int unsigned PIPE_WIDTH = 32;
   localparam int unsigned PIPE_CNT_W = 16;

   // IF/ID carries only instruction + PC; a bubble is an all-zero NOP already.
   localparam logic [31:0] IFID_CTRL_MASK  = 32'h0000_0000;
   // ID/EX: RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, ALUOp[1:0].
   localparam logic [31:0] IDEX_CTRL_MASK  = 32'hFF00_0000;
   // EX/MEM: RegWrite, MemRead, MemWrite, MemToReg.
   localparam logic [31:0] EXMEM_CTRL_MASK = 32'hF000_0000;
   // MEM/WB: RegWrite, MemToReg.
   localparam logic [31:0] MEMWB_CTRL_MASK = 32'hC000_0000;

   // Number of held entries implied by a state.
   function automatic logic [1:0] state_occ(input pipe_state_e st);
      logic [1:0] occ;
      case (st)
         EMPTY:   occ = 2'd0;
         FULL:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in         clock
//   reset  in         synchronous active-low reset
//   inc    in         increment request (ignored once at the maximum value)
//   clr    in         clear to zero; wins over inc
//   count  out CNT_W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear first, then saturating increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {CNT_W{1'b0}};
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline stage register with a one-entry skid buffer so that
// in_ready is a flop and never depends combinationally on out_ready.
// Bubbles (out_valid=0) present the held word with CTRL_MASK bits forced to 0,
// so a killed or empty stage can never enable a write downstream.
// Ports:
//   clk        in          clock
//   reset      in          synchronous active-low reset
//   in_valid   in          upstream has a payload
//   in_ready   out         stage can accept (registered)
//   in_data    in  WIDTH   upstream payload
//   out_valid  out         payload presented downstream (registered)
//   out_ready  in          downstream accepts
//   out_data   out WIDTH   payload, control bits zero on a bubble (registered)
//   flush      in          discard all held entries
//   clr_stats  in          clear stall_cnt
//   stall_cnt  out CNT_W   saturating count of stalled cycles
//   occupancy  out 2       held entries, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = PIPE_WIDTH,
   parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W     = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       occupancy
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;

   // Output flops, loaded from the next-state values so they track state_q.
   logic             in_ready_q;
   logic             in_ready_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic [WIDTH-1:0] out_data_q;
   logic [WIDTH-1:0] out_data_d;
   logic [1:0]       occupancy_q;
   logic [1:0]       occupancy_d;

   logic in_fire;
   logic out_fire;
   logic stall_inc;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // State and payload registers; reset clears everything and reopens the input.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_q      <= {WIDTH{1'b0}};
         skid_q      <= {WIDTH{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
         occupancy_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         occupancy_q <= occupancy_d;
      end
   end

   // Next-state and payload movement. Flush empties the stage and keeps the
   // stored words untouched; an accept in the same cycle is dropped.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = FULL;
                  main_d  = in_data;
               end else begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  state_d = FULL;
                  main_d  = in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the new word behind main.
                  state_d = SKID;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end else begin
                  state_d = FULL;
               end
            end
            SKID: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end else begin
                  state_d = SKID;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Output values derived from the next state, captured by the output flops.
   always_comb begin
      in_ready_d  = (state_d != SKID);
      out_valid_d = (state_d != EMPTY);
      occupancy_d = state_occ(state_d);
      if (out_valid_d) begin
         out_data_d = main_d;
      end else begin
         out_data_d = main_d & ~CTRL_MASK;
      end
   end

   // A killed stage is not a stall, so flush suppresses the count.
   assign stall_inc = out_valid_q & ~out_ready & ~flush;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .clr   (clr_stats),
      .count (stall_cnt)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed vectors with hand-computed expectations, followed by a randomised
// valid/ready run checked against a queue model of the stage.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int unsigned W    = 32;
   localparam logic [31:0] MASK = 32'hF000_0000;
   localparam int unsigned CW   = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          flush;
   logic          clr_stats;
   logic [CW-1:0] stall_cnt;
   logic [1:0]    occupancy;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   logic        ri;
   logic        ro;
   logic        rf;
   logic [31:0] rd;
   logic        ir_before;
   logic        in_fire_m;
   logic        out_fire_m;

   pipe_stage_reg #(
      .WIDTH     (W),
      .CTRL_MASK (MASK),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .clr_stats (clr_stats),
      .stall_cnt (stall_cnt),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      flush     = 1'b0;
      clr_stats = 1'b0;
      tick();
      tick();

      // Reset state
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", out_data, 32'h0);
      check_eq("rst_stall", 32'(stall_cnt), 32'd0);
      check_eq("rst_occ", 32'(occupancy), 32'd0);
      reset = 1'b1;
      tick();

      // Single transfer, one cycle latency
      in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_eq("t1_out_valid", 32'(out_valid), 32'd1);
      check_eq("t1_out_data", out_data, 32'h1234_5678);
      check_eq("t1_in_ready", 32'(in_ready), 32'd1);
      check_eq("t1_occ", 32'(occupancy), 32'd1);
      tick();
      check_eq("t1_drain", 32'(out_valid), 32'd0);

      // Stream 1,2,3 with a 2-cycle downstream stall
      in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b1;
      tick();
      check_eq("t2_first", out_data, 32'h1);
      out_ready = 1'b0; in_data = 32'h2;
      tick();
      check_eq("t2_skid_occ", 32'(occupancy), 32'd2);
      check_eq("t2_skid_rdy", 32'(in_ready), 32'd0);
      check_eq("t2_hold_1", out_data, 32'h1);
      in_data = 32'h3;
      tick();
      check_eq("t2_hold_occ", 32'(occupancy), 32'd2);
      check_eq("t2_hold_data", out_data, 32'h1);
      check_eq("t2_stall2", 32'(stall_cnt), 32'd2);
      out_ready = 1'b1;
      tick();
      check_eq("t2_out2", out_data, 32'h2);
      check_eq("t2_rdy_back", 32'(in_ready), 32'd1);
      check_eq("t2_occ1", 32'(occupancy), 32'd1);
      tick();
      in_valid = 1'b0;
      check_eq("t2_out3", out_data, 32'h3);
      check_eq("t2_valid3", 32'(out_valid), 32'd1);
      tick();
      check_eq("t2_empty", 32'(out_valid), 32'd0);
      check_eq("t2_stall_final", 32'(stall_cnt), 32'd2);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check_eq("t2_clr", 32'(stall_cnt), 32'd0);

      // Flush with control-bit masking
      in_valid = 1'b1; in_data = 32'hF0F0_0001; out_ready = 1'b0;
      tick();
      check_eq("t3_loaded", out_data, 32'hF0F0_0001);
      flush = 1'b1; in_data = 32'hFFFF_FFFF;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check_eq("t3_valid", 32'(out_valid), 32'd0);
      check_eq("t3_masked", out_data, 32'h00F0_0001);
      check_eq("t3_in_ready", 32'(in_ready), 32'd1);
      check_eq("t3_occ", 32'(occupancy), 32'd0);
      check_eq("t3_nostall", 32'(stall_cnt), 32'd0);
      tick();
      check_eq("t3_discard", 32'(out_valid), 32'd0);

      // Reset while in SKID
      in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b0;
      tick();
      in_data = 32'hBB;
      tick();
      check_eq("t4_skid", 32'(occupancy), 32'd2);
      reset = 1'b0; in_data = 32'hCC;
      tick();
      check_eq("t4_in_ready", 32'(in_ready), 32'd1);
      check_eq("t4_out_valid", 32'(out_valid), 32'd0);
      check_eq("t4_out_data", out_data, 32'h0);
      check_eq("t4_stall", 32'(stall_cnt), 32'd0);
      check_eq("t4_occ", 32'(occupancy), 32'd0);
      reset = 1'b1; in_data = 32'hAB; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_eq("t4_first_valid", 32'(out_valid), 32'd1);
      check_eq("t4_first_data", out_data, 32'hAB);
      tick();
      check_eq("t4_drain", 32'(out_valid), 32'd0);

      // Stall counter saturation and clear priority
      in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      check_eq("t5_sat", 32'(stall_cnt), 32'd15);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check_eq("t5_clr", 32'(stall_cnt), 32'd0);
      tick();
      check_eq("t5_after_clr", 32'(stall_cnt), 32'd1);
      out_ready = 1'b1;
      tick();
      check_eq("t5_empty", 32'(out_valid), 32'd0);
      check_eq("t5_cnt_hold", 32'(stall_cnt), 32'd1);

      // Randomised traffic against a queue model
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         check_eq("rnd_occ", 32'(occupancy), 32'(q.size()));
         check_eq("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
         check_eq("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
         if (q.size() > 0) begin
            check_eq("rnd_out_data", out_data, q[0]);
         end
         // in_ready must not move when only out_ready changes within a cycle
         ir_before = in_ready;
         out_ready = 1'b0;
         #1;
         check_eq("rnd_comb0", 32'(in_ready), 32'(ir_before));
         out_ready = 1'b1;
         #1;
         check_eq("rnd_comb1", 32'(in_ready), 32'(ir_before));
         ri = 1'($urandom_range(0, 1));
         ro = ($urandom_range(0, 2) != 0);
         rf = ($urandom_range(0, 99) == 0);
         rd = $urandom;
         in_valid  = ri;
         in_data   = rd;
         out_ready = ro;
         flush     = rf;
         in_fire_m  = ri && (q.size() < 2);
         out_fire_m = ro && (q.size() > 0);
         tick();
         if (rf) begin
            q.delete();
         end else begin
            if (out_fire_m) begin
               void'(q.pop_front());
            end
            if (in_fire_m) begin
               q.push_back(rd);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
